float_adder: RTL and testbench
==============================

// Module: float_adder
// PURPOSE
//  IEEE 754 binary32 adder with independent valid/ack handshakes on A, B and Z.
//  Multi-cycle FSM with one operation in flight; it sits between producer and consumer FSMs in the FP datapath.
//  Rounding is round-to-nearest-even. Zeros, infinities, NaNs and denormals are handled.
// PARAMETERS
//  None. The format is fixed at binary32: 1 sign bit, 8 exponent bits (bias 127), 23 fraction bits.
// PORTS
//  clk           in   1   single clock, rising edge
//  rst           in   1   asynchronous, active-low reset
//  input_a       in   32  operand A; sampled when input_a_stb && input_a_ack
//  input_a_stb   in   1   A valid
//  input_a_ack   out  1   A ready/accepted
//  input_b       in   32  operand B; sampled when input_b_stb && input_b_ack
//  input_b_stb   in   1   B valid
//  input_b_ack   out  1   B ready/accepted
//  output_z      out  32  sum A+B; held stable while output_z_stb=1
//  output_z_stb  out  1   Z valid
//  output_z_ack  in   1   consumer accepts Z
// BEHAVIOUR
//  - Reset (rst=0, async): state=GET_A. input_a_ack, input_b_ack, output_z_stb and output_z are all 0.
//  - All outputs are registered. Each state below lasts one clock unless stated otherwise.
//  - GET_A:
//    - First cycle in the state: input_a_ack<=1.
//    - On an edge with ack && stb: latch A, ack<=0, go to GET_B.
//  - GET_B: same as GET_A, using the B ports. Then go to UNPACK.
//  - UNPACK:
//    - Split sign, exponent and mantissa; restore the hidden 1.
//    - A denormal (exp=0, frac!=0) gets exponent -126 with no hidden bit.
//  - SPECIAL: precedence is top to bottom.
//    - Either input NaN -> Z=0x7FC00000.
//    - +inf + -inf -> 0x7FC00000.
//    - One inf -> that inf.
//    - Both zero -> sign = sa&sb.
//    - One zero -> the other operand, unchanged.
//    - Any special result goes straight to PUT_Z. Otherwise go to ALIGN.
//  - ALIGN:
//    - Right-shift the smaller-exponent mantissa by the exponent difference in one cycle (barrel shifter).
//    - Keep guard and round bits; OR all lost bits into sticky.
//    - A difference >= 27 leaves only sticky.
//  - ADD:
//    - Same signs: add magnitudes.
//    - Different signs: subtract the smaller magnitude from the larger; result takes the larger operand's sign.
//    - Exact cancellation -> +0, direct to PUT_Z.
//  - NORM:
//    - Carry out -> shift right 1, exp+1, update sticky.
//    - Otherwise left-shift by the leading-zero count in one cycle.
//    - Never shift exp below -126; the result then stays denormal.
//  - ROUND:
//    - RNE: increment if g && (r | s | lsb).
//    - Mantissa overflow -> exp+1.
//  - PACK:
//    - exp > 127 -> +/-inf (0x7F800000 | sign).
//    - Denormal result -> encoded exp 0.
//    - Register output_z; output_z_stb<=1.
//  - PUT_Z:
//    - Hold output_z and output_z_stb until an edge with output_z_ack=1.
//    - Then output_z_stb<=0, go to GET_A.
//    - A stalled consumer stalls the block; no new inputs are acked meanwhile.
//  - Latency, normal path: output_z_stb rises 7 edges after the B-handshake edge.
//  - Latency, special path: output_z_stb rises 2 edges after the B-handshake edge.
//  - Asserting rst in any state aborts the operation immediately. The block then returns to GET_A with all outputs 0.
// CONFIGURATION
//  - FADD_FTZ_EN defined:
//    - Denormal inputs are treated as signed zero.
//    - Any result that would be denormal is flushed to signed zero.
//  - FADD_FTZ_EN undefined: full gradual underflow as described above (default).
// TESTING
//  - 0x404CCCCD (3.2) + 0x3FCCCCCD (1.6), stbs tied high, ack tied high
//    -> Z=0x4099999A within 16 clocks of reset release.
//  - 0x3F800000 + 0xBF800000 -> 0x00000000.
//  - 0x80000000 + 0x80000000 -> 0x80000000.
//  - 0x7F800000 + 0xFF800000 -> 0x7FC00000.
//  - 0x7FC00001 + 0x3F800000 -> 0x7FC00000.
//  - 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000.
//  - 0x00000001 + 0x00000001 -> 0x00000002. With FADD_FTZ_EN -> 0x00000000.
//  - Hold output_z_ack=0 for 10 clocks -> output_z_stb and Z stay stable, input_a_ack stays 0.
//    Ack -> output_z_stb drops, input_a_ack rises 1 clock later.
//  - Assert rst while in ALIGN -> all outputs 0 at once; the next operation completes correctly.

Source files
------------

// File: rtl/float_adder.sv
// IEEE 754 binary32 adder with valid/ack handshakes on A, B and Z; round-to-nearest-even.
// Optional build macro FADD_FTZ_EN: denormal inputs read as signed zero and denormal results flush to signed zero.
module float_adder (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] input_a,
   input  logic        input_a_stb,
   output logic        input_a_ack,
   input  logic [31:0] input_b,
   input  logic        input_b_stb,
   output logic        input_b_ack,
   output logic [31:0] output_z,
   output logic        output_z_stb,
   input  logic        output_z_ack
);

   typedef enum logic [3:0] {
      GET_A   = 4'd0, GET_B = 4'd1, UNPACK = 4'd2, SPECIAL = 4'd3, ALIGN = 4'd4,
      ADD     = 4'd5, NORM  = 4'd6, ROUND  = 4'd7, PACK    = 4'd8, PUT_Z = 4'd9
   } state_t;

   localparam logic [31:0] QNAN = 32'h7FC0_0000;

   function automatic logic is_nan(input logic [31:0] v);
      return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
   endfunction

   function automatic logic is_inf(input logic [31:0] v);
      return (v[30:23] == 8'hFF) && (v[22:0] == 23'd0);
   endfunction

   function automatic logic signed [9:0] unpack_exp(input logic [7:0] e);
      if (e == 8'd0) return -10'sd126;
      else           return $signed({2'b00, e}) - 10'sd127;
   endfunction

   function automatic logic [23:0] unpack_man(input logic [31:0] v);
`ifdef FADD_FTZ_EN
      if (v[30:23] == 8'd0) return 24'd0;
      else                  return {1'b1, v[22:0]};
`else
      return {(v[30:23] != 8'd0), v[22:0]};
`endif
   endfunction

   function automatic logic [4:0] lzc27(input logic [26:0] v);
      logic [4:0] n;
      logic       found;
      n     = 5'd27;
      found = 1'b0;
      for (int i = 26; i >= 0; i--) begin
         if (!found && v[i]) begin
            n     = 5'(26 - i);
            found = 1'b1;
         end
      end
      return n;
   endfunction

   state_t             state_q, state_d;
   logic [31:0]        a_q, a_d, b_q, b_d, z_q, z_d;
   logic               a_ack_q, a_ack_d, b_ack_q, b_ack_d, z_stb_q, z_stb_d;
   logic               sa_q, sa_d, sb_q, sb_d, s1_q, s1_d, s2_q, s2_d, zs_q, zs_d;
   logic signed [9:0]  ea_q, ea_d, eb_q, eb_d, e_q, e_d;
   logic [23:0]        ma_q, ma_d, mb_q, mb_d, man_q, man_d;
   logic [26:0]        op1_q, op1_d, op2_q, op2_d;
   logic [27:0]        sum_q, sum_d;

   logic               swap;
   logic [23:0]        big_m, sm_m;
   logic signed [9:0]  diff, max_sh, sh;
   logic [26:0]        sm_ext, aligned, lost;
   logic [27:0]        sum;
   logic               sum_sign;
   logic [4:0]         lz;
   logic [24:0]        rnd;

   // Datapath candidates for ALIGN, ADD, NORM and ROUND from the current registers
   always_comb begin
      swap   = (eb_q > ea_q);
      big_m  = swap ? mb_q : ma_q;
      sm_m   = swap ? ma_q : mb_q;
      diff   = swap ? (eb_q - ea_q) : (ea_q - eb_q);
      sm_ext = {sm_m, 3'b000};
      lost   = 27'd0;
      if (diff >= 10'sd27) begin
         aligned = {26'd0, |sm_m};
      end else begin
         aligned    = sm_ext >> diff[4:0];
         lost       = sm_ext & ((27'd1 << diff[4:0]) - 27'd1);
         aligned[0] = aligned[0] | (|lost);
      end
      if (s1_q == s2_q) begin
         sum      = {1'b0, op1_q} + {1'b0, op2_q};
         sum_sign = s1_q;
      end else if (op1_q >= op2_q) begin
         sum      = {1'b0, op1_q} - {1'b0, op2_q};
         sum_sign = s1_q;
      end else begin
         sum      = {1'b0, op2_q} - {1'b0, op1_q};
         sum_sign = s2_q;
      end
      // Left shift is capped so the exponent never drops below -126
      lz     = lzc27(sum_q[26:0]);
      max_sh = e_q + 10'sd126;
      if ($signed({5'd0, lz}) > max_sh) sh = max_sh;
      else                              sh = $signed({5'd0, lz});
      rnd = {1'b0, sum_q[26:3]} + {24'd0, sum_q[2] & (sum_q[1] | sum_q[0] | sum_q[3])};
   end

   // Next-state and register updates for the operation FSM
   always_comb begin
      state_d = state_q;
      a_d = a_q;   b_d = b_q;   z_d = z_q;
      a_ack_d = a_ack_q;   b_ack_d = b_ack_q;   z_stb_d = z_stb_q;
      sa_d = sa_q; sb_d = sb_q; s1_d = s1_q; s2_d = s2_q; zs_d = zs_q;
      ea_d = ea_q; eb_d = eb_q; e_d = e_q;
      ma_d = ma_q; mb_d = mb_q; man_d = man_q;
      op1_d = op1_q; op2_d = op2_q; sum_d = sum_q;
      case (state_q)
         GET_A: begin
            if (a_ack_q && input_a_stb) begin
               a_d = input_a;  a_ack_d = 1'b0;  state_d = GET_B;
            end else begin
               a_ack_d = 1'b1;
            end
         end
         GET_B: begin
            if (b_ack_q && input_b_stb) begin
               b_d = input_b;  b_ack_d = 1'b0;  state_d = UNPACK;
            end else begin
               b_ack_d = 1'b1;
            end
         end
         UNPACK: begin
            sa_d = a_q[31];  ea_d = unpack_exp(a_q[30:23]);  ma_d = unpack_man(a_q);
            sb_d = b_q[31];  eb_d = unpack_exp(b_q[30:23]);  mb_d = unpack_man(b_q);
            state_d = SPECIAL;
         end
         SPECIAL: begin
            z_stb_d = 1'b1;
            state_d = PUT_Z;
            if (is_nan(a_q) || is_nan(b_q))                z_d = QNAN;
            else if (is_inf(a_q) && is_inf(b_q) && (sa_q != sb_q)) z_d = QNAN;
            else if (is_inf(a_q))                          z_d = a_q;
            else if (is_inf(b_q))                          z_d = b_q;
            else if ((ma_q == 24'd0) && (mb_q == 24'd0))   z_d = {sa_q & sb_q, 31'd0};
            else if (ma_q == 24'd0)                        z_d = b_q;
            else if (mb_q == 24'd0)                        z_d = a_q;
            else begin
               z_stb_d = 1'b0;
               state_d = ALIGN;
            end
         end
         ALIGN: begin
            op1_d = {big_m, 3'b000};
            op2_d = aligned;
            s1_d  = swap ? sb_q : sa_q;
            s2_d  = swap ? sa_q : sb_q;
            e_d   = swap ? eb_q : ea_q;
            state_d = ADD;
         end
         ADD: begin
            sum_d = sum;
            zs_d  = sum_sign;
            if (sum == 28'd0) begin
               z_d = 32'd0;  z_stb_d = 1'b1;  state_d = PUT_Z;
            end else begin
               state_d = NORM;
            end
         end
         NORM: begin
            if (sum_q[27]) begin
               sum_d = {1'b0, sum_q[27:2], sum_q[1] | sum_q[0]};
               e_d   = e_q + 10'sd1;
            end else begin
               sum_d = {1'b0, sum_q[26:0] << sh[4:0]};
               e_d   = e_q - sh;
            end
            state_d = ROUND;
         end
         ROUND: begin
            if (rnd[24]) begin
               man_d = rnd[24:1];  e_d = e_q + 10'sd1;
            end else begin
               man_d = rnd[23:0];
            end
            state_d = PACK;
         end
         PACK: begin
            if (e_q > 10'sd127) begin
               z_d = {zs_q, 8'hFF, 23'd0};
            end else if (!man_q[23]) begin
`ifdef FADD_FTZ_EN
               z_d = {zs_q, 31'd0};
`else
               z_d = {zs_q, 8'd0, man_q[22:0]};
`endif
            end else begin
               z_d = {zs_q, 8'(e_q + 10'sd127), man_q[22:0]};
            end
            z_stb_d = 1'b1;
            state_d = PUT_Z;
         end
         PUT_Z: begin
            if (output_z_ack) begin
               z_stb_d = 1'b0;  state_d = GET_A;
            end else begin
               state_d = PUT_Z;
            end
         end
         default: begin
            state_d = GET_A;  a_ack_d = 1'b0;  b_ack_d = 1'b0;  z_stb_d = 1'b0;
         end
      endcase
   end

   // State, handshake and datapath registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= GET_A;
         a_q <= 32'd0;  b_q <= 32'd0;  z_q <= 32'd0;
         a_ack_q <= 1'b0;  b_ack_q <= 1'b0;  z_stb_q <= 1'b0;
         sa_q <= 1'b0;  sb_q <= 1'b0;  s1_q <= 1'b0;  s2_q <= 1'b0;  zs_q <= 1'b0;
         ea_q <= 10'sd0;  eb_q <= 10'sd0;  e_q <= 10'sd0;
         ma_q <= 24'd0;  mb_q <= 24'd0;  man_q <= 24'd0;
         op1_q <= 27'd0;  op2_q <= 27'd0;  sum_q <= 28'd0;
      end else begin
         state_q <= state_d;
         a_q <= a_d;  b_q <= b_d;  z_q <= z_d;
         a_ack_q <= a_ack_d;  b_ack_q <= b_ack_d;  z_stb_q <= z_stb_d;
         sa_q <= sa_d;  sb_q <= sb_d;  s1_q <= s1_d;  s2_q <= s2_d;  zs_q <= zs_d;
         ea_q <= ea_d;  eb_q <= eb_d;  e_q <= e_d;
         ma_q <= ma_d;  mb_q <= mb_d;  man_q <= man_d;
         op1_q <= op1_d;  op2_q <= op2_d;  sum_q <= sum_d;
      end
   end

   assign input_a_ack  = a_ack_q;
   assign input_b_ack  = b_ack_q;
   assign output_z     = z_q;
   assign output_z_stb = z_stb_q;

endmodule

// File: tb/tb_float_adder.sv
// Scoreboard bench for float_adder: directed vectors push expected sums, a monitor pops on each Z handshake.
module tb_float_adder;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] input_a, input_b, output_z;
   logic        input_a_stb, input_a_ack, input_b_stb, input_b_ack;
   logic        output_z_stb, output_z_ack;

   logic [31:0] exp_q[$];
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   float_adder dut (
      .clk(clk), .rst(rst),
      .input_a(input_a), .input_a_stb(input_a_stb), .input_a_ack(input_a_ack),
      .input_b(input_b), .input_b_stb(input_b_stb), .input_b_ack(input_b_ack),
      .output_z(output_z), .output_z_stb(output_z_stb), .output_z_ack(output_z_ack)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   // Monitor: compare every accepted Z against the oldest expected value
   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (rst === 1'b1 && output_z_stb === 1'b1 && output_z_ack === 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL z_unexpected: got %h, expected no output", output_z);
            end else begin
               check("z_value", output_z, exp_q.pop_front());
            end
         end
      end
   end

   task automatic send_a(input logic [31:0] v);
      int n = 0;
      input_a = v;
      input_a_stb = 1'b1;
      while (input_a_ack !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("a_ack_timeout", {31'd0, input_a_ack}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      input_a_stb = 1'b0;
   endtask

   task automatic send_b(input logic [31:0] v);
      int n = 0;
      input_b = v;
      input_b_stb = 1'b1;
      while (input_b_ack !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("b_ack_timeout", {31'd0, input_b_ack}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      input_b_stb = 1'b0;
   endtask

   task automatic wait_z(output int cnt);
      cnt = 0;
      while (output_z_stb !== 1'b1 && cnt < 50) begin
         @(posedge clk);
         cnt++;
         @(negedge clk);
      end
   endtask

   // Issue one operation, check latency from the B handshake edge, let Z be accepted
   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] z, input int lat);
      int cnt;
      exp_q.push_back(z);
      send_a(a);
      send_b(b);
      wait_z(cnt);
      check("latency", 32'(cnt), 32'(lat));
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, expected finish before 200000");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      rst = 1'b0;
      input_a = 32'd0;  input_b = 32'd0;
      input_a_stb = 1'b0;  input_b_stb = 1'b0;  output_z_ack = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      check("rst_a_ack", {31'd0, input_a_ack}, 32'd0);
      check("rst_b_ack", {31'd0, input_b_ack}, 32'd0);
      check("rst_z_stb", {31'd0, output_z_stb}, 32'd0);
      check("rst_z", output_z, 32'd0);

      // Strobes and ack tied high from reset release
      input_a = 32'h404C_CCCD;  input_b = 32'h3FCC_CCCD;
      input_a_stb = 1'b1;  input_b_stb = 1'b1;
      exp_q.push_back(32'h4099_999A);
      @(negedge clk);
      rst = 1'b1;
      cnt = 0;
      while (output_z_stb !== 1'b1 && cnt < 16) begin
         @(posedge clk);
         cnt++;
         @(negedge clk);
      end
      check("first_within_16", {31'd0, output_z_stb}, 32'd1);
      input_a_stb = 1'b0;  input_b_stb = 1'b0;
      @(posedge clk);
      @(negedge clk);

      run_op(32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000, 4);
      run_op(32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 2);
      run_op(32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, 2);
      run_op(32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, 2);
      run_op(32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000, 7);
      run_op(32'h3F80_0000, 32'h0000_0000, 32'h3F80_0000, 2);
      run_op(32'hFF80_0000, 32'h3F80_0000, 32'hFF80_0000, 2);
      run_op(32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 7);
      run_op(32'h4040_0000, 32'hC000_0000, 32'h3F80_0000, 7);
      run_op(32'hBF80_0000, 32'h3F00_0000, 32'hBF00_0000, 7);
      run_op(32'h3F80_0000, 32'h3380_0000, 32'h3F80_0000, 7);
      run_op(32'h3F80_0001, 32'h3380_0000, 32'h3F80_0002, 7);
`ifdef FADD_FTZ_EN
      run_op(32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 2);
      run_op(32'h0080_0000, 32'h8000_0001, 32'h0080_0000, 2);
`else
      run_op(32'h0000_0001, 32'h0000_0001, 32'h0000_0002, 7);
      run_op(32'h0080_0000, 32'h8000_0001, 32'h007F_FFFF, 7);
`endif

      // Consumer stall: Z held, no new A accepted
      output_z_ack = 1'b0;
      exp_q.push_back(32'h4080_0000);
      send_a(32'h4000_0000);
      send_b(32'h4000_0000);
      wait_z(cnt);
      check("stall_latency", 32'(cnt), 32'd7);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         @(negedge clk);
         check("stall_z_stb", {31'd0, output_z_stb}, 32'd1);
         check("stall_z", output_z, 32'h4080_0000);
         check("stall_a_ack", {31'd0, input_a_ack}, 32'd0);
      end
      output_z_ack = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("release_z_stb", {31'd0, output_z_stb}, 32'd0);
      check("release_a_ack_early", {31'd0, input_a_ack}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      check("release_a_ack", {31'd0, input_a_ack}, 32'd1);

      // Reset while in ALIGN aborts, then a fresh operation completes
      send_a(32'h3F80_0000);
      send_b(32'h3F80_0000);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("abort_a_ack", {31'd0, input_a_ack}, 32'd0);
      check("abort_b_ack", {31'd0, input_b_ack}, 32'd0);
      check("abort_z_stb", {31'd0, output_z_stb}, 32'd0);
      check("abort_z", output_z, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      run_op(32'h404C_CCCD, 32'h3FCC_CCCD, 32'h4099_999A, 7);

      repeat (3) @(negedge clk);
      check("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
